// File: rtl/i2c_byte_engine.sv
// Byte-level I2C master: executes one START/WRITE/READ/STOP per accepted command on open-drain scl/sda.
// Optional feature macro I2C_CLOCK_STRETCH_EN: P1 waits for slave clock stretching to end.
module i2c_byte_engine #(
  parameter int unsigned CLK_DIV = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] commandIn,
  input  logic [7:0] transmitDataIn,
  input  logic       transmitAckIn,
  input  logic       transmitDataLoadEn,
  input  logic       receiveDataReadReq,
  output logic [7:0] receiveData,
  output logic       receiveAck,
  output logic       receiveValid,
  output logic       transmitReady,
  inout  wire        scl,
  inout  wire        sda
);

  localparam int unsigned CntW = $clog2(CLK_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

  localparam logic [1:0] CmdStart = 2'd0;
  localparam logic [1:0] CmdWrite = 2'd1;
  localparam logic [1:0] CmdRead  = 2'd2;
  localparam logic [1:0] CmdStop  = 2'd3;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StStart = 3'd1;
  localparam logic [2:0] StWrite = 3'd2;
  localparam logic [2:0] StRead  = 3'd3;
  localparam logic [2:0] StStop  = 3'd4;
  localparam logic [2:0] StDone  = 3'd5;

  logic [2:0]      stateQ, stateD;
  logic [1:0]      phaseQ, phaseD;
  logic [3:0]      bitQ, bitD;
  logic [CntW-1:0] cntQ, cntD;
  logic [1:0]      cmdQ, cmdD;
  logic [7:0]      txShiftQ, txShiftD;
  logic            txAckQ, txAckD;
  logic [7:0]      rxShiftQ, rxShiftD;
  logic            ackSampleQ, ackSampleD;
  logic [7:0]      receiveDataQ, receiveDataD;
  logic            receiveAckQ, receiveAckD;
  logic            receiveValidQ, receiveValidD;
  logic            sclLowQ, sclLowD;
  logic            sdaLowQ, sdaLowD;
  logic            sdaMeta, sdaSync;
  logic            stretchHold;

`ifdef I2C_CLOCK_STRETCH_EN
  // Counter keeps running through the synchroniser lag so bus high time is exactly CLK_DIV.
  localparam logic [CntW-1:0] SyncLag = CntW'(CLK_DIV - 2);
  logic sclMeta, sclSync;

  always_ff @(posedge clk) begin
    if (reset) begin
      sclMeta <= 1'b1;
      sclSync <= 1'b1;
    end else begin
      sclMeta <= scl;
      sclSync <= sclMeta;
    end
  end

  assign stretchHold = (phaseQ == 2'd1) && !sclSync && (cntQ < SyncLag);
`else
  assign stretchHold = 1'b0;
`endif

  always_comb begin
    stateD        = stateQ;
    phaseD        = phaseQ;
    bitD          = bitQ;
    cntD          = cntQ;
    cmdD          = cmdQ;
    txShiftD      = txShiftQ;
    txAckD        = txAckQ;
    rxShiftD      = rxShiftQ;
    ackSampleD    = ackSampleQ;
    receiveDataD  = receiveDataQ;
    receiveAckD   = receiveAckQ;
    receiveValidD = receiveValidQ;
    sclLowD       = sclLowQ;
    sdaLowD       = sdaLowQ;

    if (receiveDataReadReq) receiveValidD = 1'b0;

    case (stateQ)
      StIdle: begin
        if (transmitDataLoadEn) begin
          cmdD     = commandIn;
          txShiftD = transmitDataIn;
          txAckD   = transmitAckIn;
          phaseD   = 2'd0;
          bitD     = 4'd0;
          cntD     = CntMax;
          case (commandIn)
            CmdStart: stateD = StStart;
            CmdWrite: stateD = StWrite;
            CmdRead:  stateD = StRead;
            default:  stateD = StStop;
          endcase
        end
      end
      StStart, StWrite, StRead, StStop: begin
        if (cntQ == '0) begin
          if ((phaseQ == 2'd2) && ((stateQ == StWrite) || (stateQ == StRead))) begin
            if (bitQ == 4'd8) ackSampleD = sdaSync;
            else              rxShiftD   = {rxShiftQ[6:0], sdaSync};
          end
          cntD   = CntMax;
          phaseD = phaseQ + 2'd1;
          if (phaseQ == 2'd3) begin
            if ((stateQ == StStart) || (stateQ == StStop) || (bitQ == 4'd8)) begin
              stateD = StDone;
            end else begin
              bitD     = bitQ + 4'd1;
              txShiftD = {txShiftQ[6:0], 1'b0};
            end
          end
        end else if (!stretchHold) begin
          cntD = cntQ - 1'b1;
        end
      end
      StDone: begin
        stateD = StIdle;
        if (cmdQ == CmdWrite) begin
          receiveAckD   = ackSampleQ;
          receiveValidD = 1'b1;
        end else if (cmdQ == CmdRead) begin
          receiveDataD  = rxShiftQ;
          receiveAckD   = txAckQ;
          receiveValidD = 1'b1;
        end
      end
      default: stateD = StIdle;
    endcase

    // Line levels are registered from the next phase so scl/sda never glitch.
    case (stateD)
      StStart: begin
        case (phaseD)
          2'd0:    sdaLowD = 1'b0;
          2'd1:    sclLowD = 1'b0;
          2'd2:    sdaLowD = 1'b1;
          default: sclLowD = 1'b1;
        endcase
      end
      StWrite, StRead: begin
        case (phaseD)
          2'd0: begin
            sclLowD = 1'b1;
            if (bitD == 4'd8) sdaLowD = (stateD == StRead) && !txAckD;
            else              sdaLowD = (stateD == StWrite) && !txShiftD[7];
          end
          2'd1:    sclLowD = 1'b0;
          2'd2:    sclLowD = 1'b0;
          default: sclLowD = 1'b1;
        endcase
      end
      StStop: begin
        case (phaseD)
          2'd0: begin
            sclLowD = 1'b1;
            sdaLowD = 1'b1;
          end
          2'd1:    sclLowD = 1'b0;
          2'd2:    sdaLowD = 1'b1;
          default: sdaLowD = 1'b0;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ        <= StIdle;
      phaseQ        <= 2'd0;
      bitQ          <= 4'd0;
      cntQ          <= '0;
      cmdQ          <= CmdStart;
      txShiftQ      <= 8'h00;
      txAckQ        <= 1'b0;
      rxShiftQ      <= 8'h00;
      ackSampleQ    <= 1'b0;
      receiveDataQ  <= 8'h00;
      receiveAckQ   <= 1'b0;
      receiveValidQ <= 1'b0;
      sclLowQ       <= 1'b0;
      sdaLowQ       <= 1'b0;
      sdaMeta       <= 1'b1;
      sdaSync       <= 1'b1;
    end else begin
      stateQ        <= stateD;
      phaseQ        <= phaseD;
      bitQ          <= bitD;
      cntQ          <= cntD;
      cmdQ          <= cmdD;
      txShiftQ      <= txShiftD;
      txAckQ        <= txAckD;
      rxShiftQ      <= rxShiftD;
      ackSampleQ    <= ackSampleD;
      receiveDataQ  <= receiveDataD;
      receiveAckQ   <= receiveAckD;
      receiveValidQ <= receiveValidD;
      sclLowQ       <= sclLowD;
      sdaLowQ       <= sdaLowD;
      sdaMeta       <= sda;
      sdaSync       <= sdaMeta;
    end
  end

  assign scl           = sclLowQ ? 1'b0 : 1'bz;
  assign sda           = sdaLowQ ? 1'b0 : 1'bz;
  assign receiveData   = receiveDataQ;
  assign receiveAck    = receiveAckQ;
  assign receiveValid  = receiveValidQ;
  assign transmitReady = (stateQ == StIdle);

endmodule

// File: tb/tb_i2c_byte_engine.sv
// Randomised bench for i2c_byte_engine: a behavioural slave/monitor on the pulled-up bus and a
// transaction-level model of receiveData/receiveAck/receiveValid.
module tb_i2c_byte_engine;

  localparam int unsigned Div = 4;
  localparam int OpShort = 4 * Div + 2;
  localparam int OpLong  = 36 * Div + 2;
  localparam logic [1:0] CmdStart = 2'd0;
  localparam logic [1:0] CmdWrite = 2'd1;
  localparam logic [1:0] CmdRead  = 2'd2;
  localparam logic [1:0] CmdStop  = 2'd3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] commandIn = 2'd0;
  logic [7:0] transmitDataIn = 8'h00;
  logic       transmitAckIn = 1'b0;
  logic       transmitDataLoadEn = 1'b0;
  logic       receiveDataReadReq = 1'b0;
  logic [7:0] receiveData;
  logic       receiveAck;
  logic       receiveValid;
  logic       transmitReady;
  wire        scl;
  wire        sda;
  logic       slaveSdaLow = 1'b0;
  logic       slaveSclLow = 1'b0;

  pullup (scl);
  pullup (sda);
  assign scl = slaveSclLow ? 1'b0 : 1'bz;
  assign sda = slaveSdaLow ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_byte_engine #(
    .CLK_DIV(Div)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .commandIn         (commandIn),
    .transmitDataIn    (transmitDataIn),
    .transmitAckIn     (transmitAckIn),
    .transmitDataLoadEn(transmitDataLoadEn),
    .receiveDataReadReq(receiveDataReadReq),
    .receiveData       (receiveData),
    .receiveAck        (receiveAck),
    .receiveValid      (receiveValid),
    .transmitReady     (transmitReady),
    .scl               (scl),
    .sda               (sda)
  );

  int numChecks = 0;
  int numFailures = 0;
  logic [7:0] modelData = 8'h00;
  logic       modelAck = 1'b0;
  logic       modelValid = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    numChecks++;
    if (obs !== exp) begin
      numFailures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issues one command, then plays slave and bus monitor cycle by cycle until ready.
  task automatic runOp(input logic [1:0] cmd, input logic [7:0] data, input logic ack,
                       input bit slaveAcks, input logic [7:0] slaveByte, input bit strayLoad,
                       input bit coincidentReq, input int stretchRise, output int lat,
                       output logic [7:0] seenByte, output logic seenAck,
                       output bit sawStart, output bit sawStop);
    int   rises;
    int   stretchLeft;
    logic prevScl, prevSda, curScl, curSda;
    @(negedge clk);
    commandIn          = cmd;
    transmitDataIn     = data;
    transmitAckIn      = ack;
    transmitDataLoadEn = 1'b1;
    prevScl            = scl;
    prevSda            = sda;
    @(posedge clk);
    #1;
    transmitDataLoadEn = 1'b0;
    lat         = 1;
    rises       = 0;
    stretchLeft = 0;
    seenByte    = 8'h00;
    seenAck     = 1'b0;
    sawStart    = 1'b0;
    sawStop     = 1'b0;
    if (cmd == CmdRead) slaveSdaLow = ~slaveByte[7];
    while (!transmitReady && lat < OpLong + 60) begin
      if (stretchLeft > 0) begin
        stretchLeft--;
        if (stretchLeft == 0) slaveSclLow = 1'b0;
      end
      curScl = slaveSclLow ? 1'b1 : scl;
      curSda = sda;
      if (prevScl && curScl && prevSda && !curSda) sawStart = 1'b1;
      if (prevScl && curScl && !prevSda && curSda) sawStop = 1'b1;
      if (!prevScl && curScl) begin
        rises++;
        if (rises <= 8) seenByte = {seenByte[6:0], curSda};
        else if (rises == 9) seenAck = curSda;
        if (stretchRise != 0 && rises == stretchRise) begin
          slaveSclLow = 1'b1;
          stretchLeft = 20;
        end
      end
      if (prevScl && !curScl && rises > 0) begin
        if (cmd == CmdWrite) slaveSdaLow = slaveAcks && (rises == 8);
        else if (cmd == CmdRead) slaveSdaLow = (rises < 8) ? ~slaveByte[7-rises] : 1'b0;
      end
      transmitDataLoadEn = strayLoad && (lat == 20);
      if (strayLoad && lat == 20) commandIn = CmdStop;
      receiveDataReadReq = coincidentReq && (lat == OpLong - 1);
      prevScl = curScl;
      prevSda = curSda;
      @(posedge clk);
      #1;
      lat++;
    end
    transmitDataLoadEn = 1'b0;
    receiveDataReadReq = 1'b0;
    slaveSdaLow        = 1'b0;
    slaveSclLow        = 1'b0;
  endtask

  task automatic doOp(input string tag, input logic [1:0] cmd, input logic [7:0] data,
                      input logic ack, input bit slaveAcks, input logic [7:0] slaveByte,
                      input bit strayLoad, input bit coincidentReq, input int stretchRise);
    int         lat;
    int         expLat;
    logic [7:0] seenByte;
    logic       seenAck;
    bit         sawStart, sawStop;
    runOp(cmd, data, ack, slaveAcks, slaveByte, strayLoad, coincidentReq, stretchRise,
          lat, seenByte, seenAck, sawStart, sawStop);
    expLat = (cmd == CmdWrite || cmd == CmdRead) ? OpLong : OpShort;
    if (stretchRise != 0) expLat += 20;
    check({tag, "_latency"}, lat, expLat);
    case (cmd)
      CmdStart: begin
        check({tag, "_start_cond"}, sawStart, 1);
        check({tag, "_scl_low"}, scl, 0);
        check({tag, "_sda_low"}, sda, 0);
      end
      CmdStop: begin
        check({tag, "_stop_cond"}, sawStop, 1);
        check({tag, "_scl_idle"}, scl, 1);
        check({tag, "_sda_idle"}, sda, 1);
      end
      CmdWrite: begin
        check({tag, "_bus_bits"}, seenByte, data);
        modelAck   = !slaveAcks;
        modelValid = 1'b1;
      end
      default: begin
        check({tag, "_ack_slot"}, seenAck, ack);
        modelData  = slaveByte;
        modelAck   = ack;
        modelValid = 1'b1;
      end
    endcase
    if (cmd == CmdWrite || cmd == CmdRead) check({tag, "_no_cond"}, sawStart | sawStop, 0);
    check({tag, "_rx_data"}, receiveData, modelData);
    check({tag, "_rx_ack"}, receiveAck, modelAck);
    check({tag, "_rx_valid"}, receiveValid, modelValid);
  endtask

  task automatic pulseReadReq();
    @(negedge clk);
    receiveDataReadReq = 1'b1;
    @(negedge clk);
    receiveDataReadReq = 1'b0;
    modelValid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    logic       a;
    bit         s;
    repeat (3) @(posedge clk);
    #1;
    check("reset_scl", scl, 1);
    check("reset_sda", sda, 1);
    check("reset_ready", transmitReady, 1);
    check("reset_valid", receiveValid, 0);
    check("reset_data", receiveData, 0);
    check("reset_ack", receiveAck, 0);
    @(negedge clk);
    reset = 1'b0;

    doOp("start1", CmdStart, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0);
    doOp("wr_a5", CmdWrite, 8'hA5, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 0);
    doOp("stop1", CmdStop, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0);

    doOp("start2", CmdStart, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0);
    doOp("rd_3c", CmdRead, 8'h00, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 0);

    // No slave: pull-ups give NACK; stray strobe mid-op must not start anything.
    doOp("wr_noslave", CmdWrite, 8'h5A, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0);
    repeat (10) @(posedge clk);
    #1;
    check("stray_ready", transmitReady, 1);
    check("stray_scl_held", scl, 0);
    pulseReadReq();
    check("lone_req_clear", receiveValid, modelValid);

    doOp("start3", CmdStart, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0);
    b = 8'($urandom);
    doOp("rd_coinc", CmdRead, 8'h00, 1'b0, 1'b0, b, 1'b0, 1'b1, 0);
    pulseReadReq();
    check("coinc_then_clear", receiveValid, modelValid);
    doOp("stop3", CmdStop, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0);

    for (int i = 0; i < 5; i++) begin
      doOp("rnd_start", CmdStart, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0);
      b = 8'($urandom);
      s = 1'($urandom_range(1));
      doOp("rnd_wr", CmdWrite, b, 1'b0, s, 8'h00, 1'b0, 1'b0, 0);
      if ($urandom_range(1) == 1) begin
        pulseReadReq();
        check("rnd_req_clear", receiveValid, modelValid);
      end
      b = 8'($urandom);
      a = 1'($urandom_range(1));
      doOp("rnd_rd", CmdRead, 8'h00, a, 1'b0, b, 1'b0, 1'b0, 0);
      doOp("rnd_stop", CmdStop, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0);
    end

`ifdef I2C_CLOCK_STRETCH_EN
    doOp("st_start", CmdStart, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0);
    doOp("st_wr", CmdWrite, 8'hC3, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 5);
    doOp("st_stop", CmdStop, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0);
`endif

    // Reset in the middle of writing 0x00: sda is held low until the reset edge.
    doOp("mr_start", CmdStart, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0);
    @(negedge clk);
    commandIn          = CmdWrite;
    transmitDataIn     = 8'h00;
    transmitDataLoadEn = 1'b1;
    @(negedge clk);
    transmitDataLoadEn = 1'b0;
    repeat (40) @(negedge clk);
    check("mr_busy", transmitReady, 0);
    check("mr_sda_driven", sda, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mr_scl_released", scl, 1);
    check("mr_sda_released", sda, 1);
    check("mr_ready", transmitReady, 1);
    check("mr_valid", receiveValid, 0);
    check("mr_data", receiveData, 0);
    @(negedge clk);
    reset = 1'b0;
    modelValid = 1'b0;
    modelData  = 8'h00;
    modelAck   = 1'b0;

    doOp("post_start", CmdStart, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0);
    doOp("post_wr", CmdWrite, 8'h96, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 0);
    doOp("post_stop", CmdStop, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", numChecks, numFailures);
    $finish;
  end

endmodule
